// File: rtl/print_line_pkg.sv
// rtl/print_line_pkg.sv - shared constants, FSM state type and CRC-8 helper for the print line serialiser
// Contents:
//   PRINT_LINE_SYNC  frame sync byte
//   ser_state_t      serialiser FSM states
//   crc8_update      one byte of CRC-8 (poly 0x07, MSB first, no reflection)
package print_line_pkg;

    localparam logic [7:0] PRINT_LINE_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        DATA,
        CRC
    } ser_state_t;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data_byte);
        logic [7:0] c;
        c = crc ^ data_byte;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/print_line_fifo.sv
// rtl/print_line_fifo.sv - line FIFO; head entry is read in place until popped
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   i_push       write i_data (accepted when not full, or when a pop happens in the same cycle)
//   i_data       entry to store
//   i_pop        release the head entry (ignored when empty)
//   o_head       current head entry
//   o_full       DEPTH entries held
//   o_empty      no entries held
//   o_level      number of entries held
module print_line_fifo
    import print_line_pkg::*;
#(
    parameter int WIDTH = 392,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (PW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
            else if (!w_do_push && w_do_pop) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/print_line_serialiser.sv
// rtl/print_line_serialiser.sv - queues completed print lines and streams them as SYNC/SEQ/DATA[/CRC] byte frames
// Optional feature macro: PRINT_LINE_SERIALISER_CRC_EN (appends CRC-8 over SEQ and data bytes)
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   i_line_valid        one-cycle pulse, i_line_data holds a completed line
//   i_line_data         dot pattern, bit HEAD_WIDTH-1 is the first dot
//   o_tx_data           stream byte
//   o_tx_valid          o_tx_data valid
//   i_tx_ready          sink accepts byte
//   i_clear_overflow    clears the sticky overflow flag
//   o_overflow          sticky, a line was dropped
//   o_fifo_level        lines queued, including the line in transmission
//   o_busy              frame in progress or lines queued
module print_line_serialiser
    import print_line_pkg::*;
#(
    parameter int HEAD_WIDTH = 384,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_line_valid,
    input  logic [HEAD_WIDTH-1:0]           i_line_data,
    output logic [7:0]                      o_tx_data,
    output logic                            o_tx_valid,
    input  logic                            i_tx_ready,
    input  logic                            i_clear_overflow,
    output logic                            o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
    output logic                            o_busy
);

    localparam int NBYTES = HEAD_WIDTH / 8;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    if (HEAD_WIDTH % 8 != 0) begin : g_bad_head_width
        $error("HEAD_WIDTH must be a multiple of 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    ser_state_t             r_state, w_state_n;
    logic [7:0]             r_tx_data, w_tx_data_n;
    logic                   r_tx_valid, w_tx_valid_n;
    logic [IDXW-1:0]        r_idx, w_idx_n, w_idx_sel;
    logic [7:0]             r_seq;
    logic                   r_overflow;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_xfer;
    logic                   w_drop;
    logic [HEAD_WIDTH+7:0]  w_head;
    logic [HEAD_WIDTH-1:0]  w_line;
    logic [HEAD_WIDTH-1:0]  w_shifted;
    logic [7:0]             w_next_byte;
`ifdef PRINT_LINE_SERIALISER_CRC_EN
    logic [7:0]             r_crc, w_crc_n, w_crc_upd;
`endif

    print_line_fifo #(
        .WIDTH (HEAD_WIDTH + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (i_line_valid),
        .i_data  ({r_seq, i_line_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    assign w_line = w_head[HEAD_WIDTH-1:0];
    assign w_xfer = r_tx_valid && i_tx_ready;
    assign w_drop = i_line_valid && w_full && !w_pop;

    // Byte lookahead: SEQ state loads data byte 0, DATA state loads byte r_idx+1.
    assign w_idx_sel   = (r_state == DATA) ? r_idx + 1'b1 : '0;
    assign w_shifted   = w_line << {w_idx_sel, 3'b000};
    assign w_next_byte = w_shifted[HEAD_WIDTH-1 -: 8];

`ifdef PRINT_LINE_SERIALISER_CRC_EN
    assign w_crc_upd = crc8_update(r_crc, r_tx_data);
`endif

    always_comb begin
        w_state_n    = r_state;
        w_tx_data_n  = r_tx_data;
        w_tx_valid_n = r_tx_valid;
        w_idx_n      = r_idx;
        w_pop        = 1'b0;
`ifdef PRINT_LINE_SERIALISER_CRC_EN
        w_crc_n      = r_crc;
`endif
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_n    = SYNC;
                    w_tx_valid_n = 1'b1;
                    w_tx_data_n  = PRINT_LINE_SYNC;
                end
            end
            SYNC: begin
                if (w_xfer) begin
                    w_state_n   = SEQ;
                    w_tx_data_n = w_head[HEAD_WIDTH+7:HEAD_WIDTH];
                end
            end
            SEQ: begin
                if (w_xfer) begin
                    w_state_n   = DATA;
                    w_idx_n     = '0;
                    w_tx_data_n = w_next_byte;
`ifdef PRINT_LINE_SERIALISER_CRC_EN
                    w_crc_n     = crc8_update(8'h00, r_tx_data);
`endif
                end
            end
            DATA: begin
                if (w_xfer) begin
                    if (r_idx == IDXW'(NBYTES - 1)) begin
`ifdef PRINT_LINE_SERIALISER_CRC_EN
                        w_state_n    = CRC;
                        w_tx_data_n  = w_crc_upd;
`else
                        w_state_n    = IDLE;
                        w_tx_valid_n = 1'b0;
                        w_pop        = 1'b1;
`endif
                    end else begin
                        w_idx_n     = w_idx_sel;
                        w_tx_data_n = w_next_byte;
`ifdef PRINT_LINE_SERIALISER_CRC_EN
                        w_crc_n     = w_crc_upd;
`endif
                    end
                end
            end
`ifdef PRINT_LINE_SERIALISER_CRC_EN
            CRC: begin
                if (w_xfer) begin
                    w_state_n    = IDLE;
                    w_tx_valid_n = 1'b0;
                    w_pop        = 1'b1;
                end
            end
`endif
            default: begin
                w_state_n    = IDLE;
                w_tx_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_idx      <= '0;
            r_seq      <= 8'h00;
            r_overflow <= 1'b0;
`ifdef PRINT_LINE_SERIALISER_CRC_EN
            r_crc      <= 8'h00;
`endif
        end else begin
            r_state    <= w_state_n;
            r_tx_data  <= w_tx_data_n;
            r_tx_valid <= w_tx_valid_n;
            r_idx      <= w_idx_n;
            // Dropped lines still consume a sequence number so the host sees the gap.
            if (i_line_valid) r_seq <= r_seq + 8'd1;
            if (w_drop)                r_overflow <= 1'b1;
            else if (i_clear_overflow) r_overflow <= 1'b0;
`ifdef PRINT_LINE_SERIALISER_CRC_EN
            r_crc      <= w_crc_n;
`endif
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_overflow = r_overflow;
    assign o_busy     = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_print_line_serialiser.sv
// tb/tb_print_line_serialiser.sv - self-checking bench for print_line_serialiser (HEAD_WIDTH=16, FIFO_DEPTH=2)
module tb_print_line_serialiser;

    localparam int HW = 16;
    localparam int FD = 2;
    localparam int LW = $clog2(FD) + 1;
`ifdef PRINT_LINE_SERIALISER_CRC_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          line_valid = 1'b0;
    logic [HW-1:0] line_data = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          clear_overflow = 1'b0;
    logic          overflow;
    logic [LW-1:0] fifo_level;
    logic          busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] seq_m = 8'h00;
    logic       stalled = 1'b0;
    logic [7:0] stall_data = 8'h00;

    print_line_serialiser #(
        .HEAD_WIDTH (HW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_line_valid     (line_valid),
        .i_line_data      (line_data),
        .o_tx_data        (tx_data),
        .o_tx_valid       (tx_valid),
        .i_tx_ready       (tx_ready),
        .i_clear_overflow (clear_overflow),
        .o_overflow       (overflow),
        .o_fifo_level     (fifo_level),
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    // Byte monitor: a transfer happens at the next rising edge when valid && ready here.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (!reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
                    errors++;
                    $display("FAIL stall_hold: tx_valid=%b tx_data=%h, required tx_valid=1 tx_data=%h",
                             tx_valid, tx_data, stall_data);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %h, required no byte", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL frame_byte: got %h, required %h", tx_data, e);
                    end
                end
            end
            stalled    = (tx_valid === 1'b1 && tx_ready === 1'b0);
            stall_data = tx_data;
        end
    end

    function automatic logic [7:0] model_crc(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic pulse_line(input logic [HW-1:0] data, input bit accept);
        logic [7:0] crc;
        line_data  = data;
        line_valid = 1'b1;
        if (accept) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(seq_m);
            crc = model_crc(8'h00, seq_m);
            for (int k = 0; k < HW / 8; k++) begin
                exp_q.push_back(data[HW-1-8*k -: 8]);
                crc = model_crc(crc, data[HW-1-8*k -: 8]);
            end
`ifdef PRINT_LINE_SERIALISER_CRC_EN
            exp_q.push_back(crc);
`endif
        end
        seq_m = seq_m + 8'd1;
        @(posedge clk);
        #1;
        line_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: busy=%b bytes_pending=%0d, required busy=0 bytes_pending=0",
                     name, busy, exp_q.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        seq_m = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
        checks++;
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        checks++;
        if (fifo_level !== '0) begin errors++; $display("FAIL reset_fifo_level: got %0d, required 0", fifo_level); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        reset = 1'b1;
        seq_m = 8'h00;
    endtask

    task automatic test_single_line();
        tx_ready = 1'b1;
        pulse_line(16'h1234, 1'b1);
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL latency_n1: tx_valid=%b, required 0", tx_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL latency_n2: tx_valid=%b tx_data=%h, required tx_valid=1 tx_data=a5", tx_valid, tx_data);
        end
        wait_idle(50, "single");
        checks++;
        if (busy !== 1'b0 || fifo_level !== '0) begin
            errors++;
            $display("FAIL single_end: busy=%b fifo_level=%0d, required busy=0 fifo_level=0", busy, fifo_level);
        end
    endtask

    task automatic test_backpressure();
        bit done;
        tx_ready = 1'b0;
        pulse_line(16'hBEEF, 1'b1);
        pulse_line(16'h0F5A, 1'b1);
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            #1;
            tx_ready = 1'($urandom_range(0, 1));
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        tx_ready = 1'b1;
        wait_idle(50, "backpressure");
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        pulse_line(16'h1111, 1'b1);
        pulse_line(16'h2222, 1'b1);
        pulse_line(16'h3333, 1'b0);
        checks++;
        if (fifo_level !== LW'(2)) begin errors++; $display("FAIL ovf_level: got %0d, required 2", fifo_level); end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", overflow); end
        tx_ready = 1'b1;
        wait_idle(60, "ovf_release");
        pulse_line(16'h4444, 1'b1);
        wait_idle(40, "ovf_next");
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
        clear_overflow = 1'b1;
        @(posedge clk);
        #1;
        clear_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
        tx_ready = 1'b0;
        pulse_line(16'h5555, 1'b1);
        pulse_line(16'h6666, 1'b1);
        clear_overflow = 1'b1;
        pulse_line(16'h7777, 1'b0);
        clear_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b, required 1", overflow); end
        tx_ready = 1'b1;
        wait_idle(60, "ovf_set_wins");
        clear_overflow = 1'b1;
        @(posedge clk);
        #1;
        clear_overflow = 1'b0;
    endtask

    task automatic test_full_pop();
        tx_ready = 1'b0;
        pulse_line(16'hA1B2, 1'b1);
        pulse_line(16'hC3D4, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fifo_level !== LW'(2)) begin errors++; $display("FAIL fullpop_level_pre: got %0d, required 2", fifo_level); end
        tx_ready = 1'b1;
        repeat (FRAME_LEN - 1) @(posedge clk);
        #1;
        pulse_line(16'hE5F6, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %b, required 0", overflow); end
        checks++;
        if (fifo_level !== LW'(2)) begin errors++; $display("FAIL fullpop_level_post: got %0d, required 2", fifo_level); end
        wait_idle(60, "fullpop");
    endtask

    task automatic test_reset_mid_frame();
        tx_ready = 1'b1;
        pulse_line(16'h9ABC, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != FRAME_LEN - 2) begin
            errors++;
            $display("FAIL midreset_progress: bytes_pending=%0d, required %0d", exp_q.size(), FRAME_LEN - 2);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL midreset_tx_valid: got %b, required 0", tx_valid); end
        checks++;
        if (fifo_level !== '0) begin errors++; $display("FAIL midreset_level: got %0d, required 0", fifo_level); end
        exp_q.delete();
        seq_m = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        pulse_line(16'h5A3C, 1'b1);
        wait_idle(40, "midreset_after");
    endtask

    task automatic test_seq_wrap();
        do_reset();
        tx_ready = 1'b1;
        for (int n = 0; n < 257; n++) begin
            pulse_line(16'($urandom), 1'b1);
            wait_idle(40, "seq_wrap");
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_reset_mid_frame();
        test_seq_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
